// File: rtl/mem_map_pkg.sv
// Shared memory-map constants, FSM state codes and bus payload types for the
// CPU-side memory bus controller.
package mem_map_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 8;
    // Each window is 2**REGION_AW bytes; the upper address bits select the page.
    localparam int unsigned REGION_AW = 8;
    localparam int unsigned PAGE_W    = ADDR_W - REGION_AW;
    localparam int unsigned WC_W      = 4;
    localparam int unsigned MAX_WAIT  = (1 << WC_W) - 1;

    localparam logic [ADDR_W-1:0] ROM_BASE_DEF = 16'hFF00;
    localparam logic [ADDR_W-1:0] RAM_BASE_DEF = 16'h0000;
    localparam logic [DATA_W-1:0] ERR_DATA     = 8'hFF;

    typedef logic [2:0] bus_state_t;
    localparam bus_state_t ST_IDLE    = 3'd0;
    localparam bus_state_t ST_ROM_ACC = 3'd1;
    localparam bus_state_t ST_RAM_ACC = 3'd2;
    localparam bus_state_t ST_ERR     = 3'd3;
    localparam bus_state_t ST_ACK     = 3'd4;

    // One-hot region hit vector {hit_rom, hit_ram, hit_none}
    typedef logic [2:0] region_hit_t;
    localparam region_hit_t HIT_ROM  = 3'b100;
    localparam region_hit_t HIT_RAM  = 3'b010;
    localparam region_hit_t HIT_NONE = 3'b001;

    typedef struct packed {
        logic                 we;
        logic [REGION_AW-1:0] offs;
        logic [DATA_W-1:0]    wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational page decode of a CPU address into ROM / RAM / unmapped.
// ROM wins if both windows were ever configured onto the same page.
module mem_addr_decode
    import mem_map_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_BASE = ROM_BASE_DEF,
    parameter logic [ADDR_W-1:0] RAM_BASE = RAM_BASE_DEF
) (
    input  logic [PAGE_W-1:0] page_i,
    output region_hit_t       hit_c_o
);

    always_comb begin
        hit_c_o = HIT_NONE;
        if (page_i == ROM_BASE[ADDR_W-1:REGION_AW]) begin
            hit_c_o = HIT_ROM;
        end else if (page_i == RAM_BASE[ADDR_W-1:REGION_AW]) begin
            hit_c_o = HIT_RAM;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-side memory bus controller: one byte access at a time to async ROM/RAM
// with programmable wait states, registered read data and one-cycle ack.
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter int unsigned       ROM_WAIT = 2,
    parameter int unsigned       RAM_WAIT = 1,
    parameter logic [ADDR_W-1:0] ROM_BASE = ROM_BASE_DEF,
    parameter logic [ADDR_W-1:0] RAM_BASE = RAM_BASE_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_ack,
    output logic                 bus_err,
    output logic                 rom_sel,
    output logic [REGION_AW-1:0] rom_a,
    input  logic [DATA_W-1:0]    rom_dout,
    output logic                 ram_sel,
    output logic                 ram_we,
    output logic [REGION_AW-1:0] ram_a,
    output logic [DATA_W-1:0]    ram_din,
    input  logic [DATA_W-1:0]    ram_dout
);

    // Wait counts must fit the 4-bit counter; windows must be page aligned.
    if (ROM_WAIT > MAX_WAIT) begin : g_rom_wait_chk
        $error("ROM_WAIT exceeds the wait counter range");
    end
    if (RAM_WAIT > MAX_WAIT) begin : g_ram_wait_chk
        $error("RAM_WAIT exceeds the wait counter range");
    end
    if (ROM_BASE[REGION_AW-1:0] != '0) begin : g_rom_base_chk
        $error("ROM_BASE is not window aligned");
    end
    if (RAM_BASE[REGION_AW-1:0] != '0) begin : g_ram_base_chk
        $error("RAM_BASE is not window aligned");
    end

    region_hit_t       hit;
    bus_state_t        state_q, state_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    bus_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rom_sel_q, rom_sel_d;
    logic              ram_sel_q, ram_sel_d;
    logic              ram_we_q, ram_we_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    mem_addr_decode #(
        .ROM_BASE (ROM_BASE),
        .RAM_BASE (RAM_BASE)
    ) u_decode (
        .page_i  (cpu_addr[ADDR_W-1:REGION_AW]),
        .hit_c_o (hit)
    );

    // State, wait counter and request/data registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wc_q      <= '0;
            req_q     <= '0;
            rdata_q   <= '0;
            rom_sel_q <= 1'b0;
            ram_sel_q <= 1'b0;
            ram_we_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wc_q      <= wc_d;
            req_q     <= req_d;
            rdata_q   <= rdata_d;
            rom_sel_q <= rom_sel_d;
            ram_sel_q <= ram_sel_d;
            ram_we_q  <= ram_we_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Next state; strobes are decoded from the next state so they register cleanly
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        req_d   = req_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    req_d.we    = cpu_we;
                    req_d.offs  = cpu_addr[REGION_AW-1:0];
                    req_d.wdata = cpu_wdata;
                    case (hit)
                        HIT_ROM: begin
                            if (cpu_we) begin
                                state_d = ST_ERR;
                            end else begin
                                state_d = ST_ROM_ACC;
                                wc_d    = WC_W'(ROM_WAIT);
                            end
                        end
                        HIT_RAM: begin
                            state_d = ST_RAM_ACC;
                            wc_d    = WC_W'(RAM_WAIT);
                        end
                        default: state_d = ST_ERR;
                    endcase
                end
            end
            ST_ROM_ACC: begin
                if (wc_q == '0) begin
                    state_d = ST_ACK;
                    rdata_d = rom_dout;
                end else begin
                    wc_d = wc_q - WC_W'(1);
                end
            end
            ST_RAM_ACC: begin
                if (wc_q == '0) begin
                    state_d = ST_ACK;
                    if (!req_q.we) begin
                        rdata_d = ram_dout;
                    end
                end else begin
                    wc_d = wc_q - WC_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ACK;
                if (!req_q.we) begin
                    rdata_d = ERR_DATA;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        rom_sel_d = (state_d == ST_ROM_ACC);
        ram_sel_d = (state_d == ST_RAM_ACC);
        ram_we_d  = ram_sel_d && req_d.we && (wc_d == '0);
        ack_d     = (state_d == ST_ACK);
        err_d     = (state_q == ST_ERR);
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign bus_err   = err_q;
    assign rom_sel   = rom_sel_q;
    assign rom_a     = req_q.offs;
    assign ram_sel   = ram_sel_q;
    assign ram_we    = ram_we_q;
    assign ram_a     = req_q.offs;
    assign ram_din   = req_q.wdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed corner cases plus randomized
// accesses checked against a transaction-level memory-map model.
module tb_mem_bus_ctrl;

    localparam int unsigned ROM_WAIT = 2;
    localparam int unsigned RAM_WAIT = 1;
    localparam int K_ROM = 0;
    localparam int K_RAM = 1;
    localparam int K_ERR = 2;

    logic        clk;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        bus_err;
    logic        rom_sel;
    logic [7:0]  rom_a;
    logic [7:0]  rom_dout;
    logic        ram_sel;
    logic        ram_we;
    logic [7:0]  ram_a;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    logic [7:0] rom_img  [256];
    logic [7:0] ram_phys [256];
    logic [7:0] ram_ref  [256];
    logic [7:0] exp_rd;

    int n_cmp;
    int n_err;
    int both_cnt;

    mem_bus_ctrl #(
        .ROM_WAIT (ROM_WAIT),
        .RAM_WAIT (RAM_WAIT),
        .ROM_BASE (16'hFF00),
        .RAM_BASE (16'h0000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .bus_err   (bus_err),
        .rom_sel   (rom_sel),
        .rom_a     (rom_a),
        .rom_dout  (rom_dout),
        .ram_sel   (ram_sel),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async memory models
    assign rom_dout = rom_img[rom_a];
    assign ram_dout = ram_phys[ram_a];
    always @(posedge clk) begin
        if (ram_sel && ram_we) ram_phys[ram_a] <= ram_din;
    end

    always @(negedge clk) begin
        if (rom_sel && ram_sel) both_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int kind_of(input logic [15:0] a, input logic w);
        logic [7:0] page;
        page = a[15:8];
        if (page == 8'hFF) return w ? K_ERR : K_ROM;
        if (page == 8'h00) return K_RAM;
        return K_ERR;
    endfunction

    function automatic logic [36:0] out_vec();
        return {cpu_rdata, cpu_ack, bus_err, rom_sel, rom_a, ram_sel, ram_we, ram_a, ram_din};
    endfunction

    // Issue one request from a negedge in an IDLE cycle; returns at the negedge after the ack.
    task automatic do_access(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        int kind, exp_lat, lat, n_rom, n_ram, n_we;
        logic [7:0] offs;
        kind  = kind_of(addr, we);
        offs  = addr[7:0];
        exp_lat = (kind == K_ROM) ? int'(ROM_WAIT) + 2 :
                  (kind == K_RAM) ? int'(RAM_WAIT) + 2 : 2;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        lat = 0; n_rom = 0; n_ram = 0; n_we = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) cpu_req = 1'b0;
            if (rom_sel) begin
                n_rom++;
                chk("rom_a", rom_a, offs);
            end
            if (ram_sel) begin
                n_ram++;
                chk("ram_a", ram_a, offs);
            end
            if (ram_we) begin
                n_we++;
                chk("ram_we_cycle", k, RAM_WAIT + 1);
                chk("ram_din", ram_din, wd);
            end
            if (cpu_ack) lat = k;
        end
        if (kind == K_ROM) exp_rd = rom_img[offs];
        else if (kind == K_RAM && !we) exp_rd = ram_ref[offs];
        else if (kind == K_ERR && !we) exp_rd = 8'hFF;
        if (kind == K_RAM && we) ram_ref[offs] = wd;
        chk("ack_latency", lat, exp_lat);
        chk("bus_err", bus_err, kind == K_ERR);
        chk("rdata", cpu_rdata, exp_rd);
        chk("rom_sel_cycles", n_rom, (kind == K_ROM) ? ROM_WAIT + 1 : 0);
        chk("ram_sel_cycles", n_ram, (kind == K_RAM) ? RAM_WAIT + 1 : 0);
        chk("ram_we_pulses", n_we, (kind == K_RAM && we) ? 1 : 0);
        @(negedge clk);
        chk("ack_single", {cpu_ack, bus_err}, 2'b00);
    endtask

    initial begin
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        we;
        n_cmp = 0; n_err = 0; both_cnt = 0;
        exp_rd = 8'h00;
        for (int i = 0; i < 256; i++) begin
            rom_img[i] = 8'($urandom);
            ram_ref[i] = 8'h00;
        end
        rom_img[8'hFE] = 8'hFF;

        // Reset held with a pending request
        reset_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0;
        cpu_addr = 16'hFFFE; cpu_wdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", out_vec(), '0);
        end
        reset_n = 1'b1;
        do_access(1'b0, 16'hFFFE, 8'h00);

        // RAM write then read-back
        do_access(1'b1, 16'h0010, 8'hA5);
        do_access(1'b0, 16'h0010, 8'h00);

        // Fill the RAM locations the random phase reads from
        for (int i = 0; i < 16; i++) do_access(1'b1, 16'(i), 8'($urandom));
        do_access(1'b1, 16'h00FF, 8'($urandom));

        // Unmapped read, ROM write, unmapped write
        do_access(1'b0, 16'h4000, 8'h00);
        do_access(1'b0, 16'h0010, 8'h00);
        do_access(1'b1, 16'hFF00, 8'h3C);
        do_access(1'b1, 16'h0100, 8'h77);

        // Reset pulsed in the middle of a ROM access with the request held
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF10; cpu_wdata = 8'h00;
        @(negedge clk);
        chk("abort_rom_sel", rom_sel, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", out_vec(), '0);
        exp_rd = 8'h00;
        reset_n = 1'b1;
        do_access(1'b0, 16'hFF10, 8'h00);

        // Randomized mix across windows and their boundaries
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            wd = 8'($urandom);
            case ($urandom_range(0, 7))
                0, 1:    addr = {8'hFF, 8'($urandom)};
                2, 3:    addr = {8'h00, 4'h0, 4'($urandom)};
                4:       addr = {8'($urandom_range(1, 254)), 8'($urandom)};
                5:       addr = 16'h0100;
                6:       addr = 16'hFEFF;
                default: addr = 16'h00FF;
            endcase
            do_access(we, addr, wd);
        end

        chk("sel_exclusive", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
